// File: rtl/video_timing_pkg.sv
// Shared timing constants (VGA 640x480@60), coordinate-width helper and the
// per-pixel flag payload carried from decode to the output register.
package video_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_SCALE_SHIFT = 3;

  // Bits needed to hold the largest of (H_TOTAL-1, V_TOTAL-1).
  function automatic int unsigned coord_width(input int unsigned h_total,
                                              input int unsigned v_total);
    int unsigned span;
    span = (h_total > v_total) ? h_total : v_total;
    return (span > 1) ? int'($clog2(span)) : 1;
  endfunction

  localparam int unsigned VGA_CW = coord_width(VGA_H_TOTAL, VGA_V_TOTAL);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic fetch;
    logic line_start;
    logic frame_start;
  } pixel_flags_t;

endpackage

// File: rtl/timing_axis_counter.sv
// One timing axis: wrapping position counter with active and sync decode.
// wrap/active/sync are decoded from the current count, not registered.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter bit          POL    = 1'b1,
  parameter int unsigned CW     = VGA_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

  always_comb begin
    wrap   = (count == LAST);
    active = (count < ACTIVE_END);
    sync   = ((count >= SYNC_START) && (count < SYNC_END)) ? POL : ~POL;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: chained H/V counters decoded into a registered
// pixel description (syncs, active, raw and replicated coordinates, pulses).
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter bit          HSYNC_POL   = 1'b1,
  parameter bit          VSYNC_POL   = 1'b1,
  parameter int unsigned SCALE_SHIFT = VGA_SCALE_SHIFT,
  parameter int unsigned CW          = VGA_CW
) (
  input  logic          PClk,
  input  logic          Reset,
  input  logic          Enable,
  output logic          hsync,
  output logic          vsync,
  output logic          activeArea,
  output logic [CW-1:0] CounterX,
  output logic [CW-1:0] CounterY,
  output logic [CW-1:0] ScaledX,
  output logic [CW-1:0] ScaledY,
  output logic          fetchStrobe,
  output logic          lineStart,
  output logic          frameStart
);

  localparam logic [CW-1:0] SCALE_MASK = CW'((1 << SCALE_SHIFT) - 1);
  localparam pixel_flags_t  FLAGS_RESET = pixel_flags_t'({~HSYNC_POL, ~VSYNC_POL, 4'b0000});

  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_active;
  logic          v_active;
  logic          h_sync;
  logic          v_sync;
  logic          v_advance_c;
  logic          at_origin;

  pixel_flags_t  flags_c;
  pixel_flags_t  flags_q;
  logic [CW-1:0] scaled_x_c;
  logic [CW-1:0] scaled_y_c;

  assign v_advance_c = Enable & h_wrap;

  timing_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk     (PClk),
    .rst     (Reset),
    .advance (Enable),
    .count   (x),
    .wrap    (h_wrap),
    .active  (h_active),
    .sync    (h_sync)
  );

  timing_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk     (PClk),
    .rst     (Reset),
    .advance (v_advance_c),
    .count   (y),
    .wrap    (v_wrap),
    .active  (v_active),
    .sync    (v_sync)
  );

  // Tracks whether the counters currently sit on pixel (0,0).
  always_ff @(posedge PClk or posedge Reset) begin
    if (Reset) begin
      at_origin <= 1'b1;
    end else if (Enable) begin
      at_origin <= h_wrap & v_wrap;
    end
  end

  // Decode of the pixel the counters point at; registered below.
  always_comb begin
    flags_c             = '0;
    flags_c.hsync       = h_sync;
    flags_c.vsync       = v_sync;
    flags_c.active      = h_active & v_active;
    flags_c.fetch       = h_active & v_active & ((x & SCALE_MASK) == '0);
    flags_c.line_start  = (x == '0);
    flags_c.frame_start = at_origin;
    scaled_x_c          = h_active ? (x >> SCALE_SHIFT) : '0;
    scaled_y_c          = v_active ? (y >> SCALE_SHIFT) : '0;
  end

  // While disabled everything holds except the pulses, which drop to zero.
  always_ff @(posedge PClk or posedge Reset) begin
    if (Reset) begin
      flags_q  <= FLAGS_RESET;
      CounterX <= '0;
      CounterY <= '0;
      ScaledX  <= '0;
      ScaledY  <= '0;
    end else if (Enable) begin
      flags_q  <= flags_c;
      CounterX <= x;
      CounterY <= y;
      ScaledX  <= scaled_x_c;
      ScaledY  <= scaled_y_c;
    end else begin
      flags_q.fetch       <= 1'b0;
      flags_q.line_start  <= 1'b0;
      flags_q.frame_start <= 1'b0;
    end
  end

  assign hsync       = flags_q.hsync;
  assign vsync       = flags_q.vsync;
  assign activeArea  = flags_q.active;
  assign fetchStrobe = flags_q.fetch;
  assign lineStart   = flags_q.line_start;
  assign frameStart  = flags_q.frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three configurations (VGA default, small with
// inverted syncs and no scaling, small with 2x scaling) checked every cycle.
module tb_video_timing_gen;

  typedef struct packed {
    logic       hs, vs, act, ft, ls, fs;
    logic [9:0] cx, cy, sx, sy;
  } obs_t;

  typedef struct packed {
    logic [1:0] id;
    obs_t       o;
  } sb_t;

  localparam int HA [3] = '{640, 8, 8};
  localparam int HFP[3] = '{16, 2, 2};
  localparam int HSY[3] = '{96, 2, 2};
  localparam int HBP[3] = '{48, 4, 4};
  localparam int VA [3] = '{480, 4, 4};
  localparam int VFP[3] = '{10, 1, 1};
  localparam int VSY[3] = '{2, 1, 1};
  localparam int VBP[3] = '{33, 2, 2};
  localparam bit HP [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit VP [3] = '{1'b1, 1'b0, 1'b1};
  localparam int SH [3] = '{3, 0, 1};

  logic       clk = 1'b0;
  logic [2:0] rs;
  logic [2:0] en;

  logic       hs_w [3], vs_w [3], act_w [3], ft_w [3], ls_w [3], fs_w [3];
  logic [9:0] cx_w [3], cy_w [3], sx_w [3], sy_w [3];
  obs_t       dut_o [3];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   mx [3];
  int   my [3];
  obs_t last [3];
  sb_t  exp_q [$];
  bit   started = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen u_dut0 (
    .PClk(clk), .Reset(rs[0]), .Enable(en[0]),
    .hsync(hs_w[0]), .vsync(vs_w[0]), .activeArea(act_w[0]),
    .CounterX(cx_w[0]), .CounterY(cy_w[0]), .ScaledX(sx_w[0]), .ScaledY(sy_w[0]),
    .fetchStrobe(ft_w[0]), .lineStart(ls_w[0]), .frameStart(fs_w[0])
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE_SHIFT(0), .CW(10)
  ) u_dut1 (
    .PClk(clk), .Reset(rs[1]), .Enable(en[1]),
    .hsync(hs_w[1]), .vsync(vs_w[1]), .activeArea(act_w[1]),
    .CounterX(cx_w[1]), .CounterY(cy_w[1]), .ScaledX(sx_w[1]), .ScaledY(sy_w[1]),
    .fetchStrobe(ft_w[1]), .lineStart(ls_w[1]), .frameStart(fs_w[1])
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SCALE_SHIFT(1), .CW(10)
  ) u_dut2 (
    .PClk(clk), .Reset(rs[2]), .Enable(en[2]),
    .hsync(hs_w[2]), .vsync(vs_w[2]), .activeArea(act_w[2]),
    .CounterX(cx_w[2]), .CounterY(cy_w[2]), .ScaledX(sx_w[2]), .ScaledY(sy_w[2]),
    .fetchStrobe(ft_w[2]), .lineStart(ls_w[2]), .frameStart(fs_w[2])
  );

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dut_o[i] = {hs_w[i], vs_w[i], act_w[i], ft_w[i], ls_w[i], fs_w[i],
                  cx_w[i], cy_w[i], sx_w[i], sy_w[i]};
    end
  end

  function automatic obs_t reset_obs(input int id);
    obs_t o;
    o    = '0;
    o.hs = !HP[id];
    o.vs = !VP[id];
    return o;
  endfunction

  // Expected registered description of pixel (x,y) for configuration id.
  function automatic obs_t model(input int id, input int x, input int y);
    obs_t o;
    int   hss;
    int   vss;
    hss   = HA[id] + HFP[id];
    vss   = VA[id] + VFP[id];
    o.hs  = (x >= hss && x < hss + HSY[id]) ? HP[id] : !HP[id];
    o.vs  = (y >= vss && y < vss + VSY[id]) ? VP[id] : !VP[id];
    o.act = (x < HA[id]) && (y < VA[id]);
    o.ft  = o.act && ((x % (1 << SH[id])) == 0);
    o.ls  = (x == 0);
    o.fs  = (x == 0) && (y == 0);
    o.cx  = 10'(x);
    o.cy  = 10'(y);
    o.sx  = (x < HA[id]) ? 10'(x >> SH[id]) : 10'd0;
    o.sy  = (y < VA[id]) ? 10'(y >> SH[id]) : 10'd0;
    return o;
  endfunction

  // Stimulus-side scoreboard feed: one expected entry per DUT per clock.
  always @(posedge clk) begin
    for (int id = 0; id < 3; id++) begin
      sb_t s;
      int  ht;
      int  vt;
      ht = HA[id] + HFP[id] + HSY[id] + HBP[id];
      vt = VA[id] + VFP[id] + VSY[id] + VBP[id];
      if (rs[id]) begin
        mx[id]   = 0;
        my[id]   = 0;
        last[id] = reset_obs(id);
      end else if (en[id]) begin
        last[id] = model(id, mx[id], my[id]);
        if (mx[id] == ht - 1) begin
          mx[id] = 0;
          my[id] = (my[id] == vt - 1) ? 0 : my[id] + 1;
        end else begin
          mx[id] = mx[id] + 1;
        end
      end else begin
        last[id].ft = 1'b0;
        last[id].ls = 1'b0;
        last[id].fs = 1'b0;
      end
      s.id = 2'(id);
      s.o  = last[id];
      exp_q.push_back(s);
    end
    started = 1'b1;
  end

  // Monitor: pops and compares each DUT's presented pixel every cycle.
  always @(negedge clk) begin
    if (started) begin
      for (int id = 0; id < 3; id++) begin
        sb_t  s;
        obs_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty dut%0d t=%0t", id, $time);
        end else begin
          s = exp_q.pop_front();
          e = rs[id] ? reset_obs(id) : s.o;
          if (s.id != 2'(id) || dut_o[id] !== e) begin
            n_fail++;
            $display("FAIL sb_dut%0d t=%0t got=%h exp=%h", id, $time, dut_o[id], e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, actual, expected);
    end
  endtask

  int exp_sx [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int hs_n, hs_first, ft_n, ft_bad, act_n, ls_n;
  int h1_low, v1_low, ft1_n, v2_hi, fs2_n, fs2_second, ft2_pat, g;

  initial begin
    rs = 3'b111;
    en = 3'b111;
    hs_n = 0; hs_first = -1; ft_n = 0; ft_bad = 0; act_n = 0; ls_n = 0;
    h1_low = 0; v1_low = 0; ft1_n = 0; v2_hi = 0; fs2_n = 0; fs2_second = -1; ft2_pat = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cx0", int'(cx_w[0]), 0);
    chk("rst_hs0", int'(hs_w[0]), 0);
    chk("rst_act0", int'(act_w[0]), 0);
    chk("rst_hs1_pol0", int'(hs_w[1]), 1);
    chk("rst_vs1_pol0", int'(vs_w[1]), 1);

    @(posedge clk);
    #2 rs = 3'b000;
    @(posedge clk);

    // First 800 pixels: one full default line, many small frames.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("first_fs0", int'(fs_w[0]), 1);
        chk("first_act0", int'(act_w[0]), 1);
        chk("first_ft0", int'(ft_w[0]), 1);
        chk("first_cx0", int'(cx_w[0]), 0);
      end
      if (hs_w[0]) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(cx_w[0]);
      end
      if (ft_w[0]) begin
        ft_n++;
        if ((int'(cx_w[0]) % 8) != 0) ft_bad++;
      end
      if (act_w[0]) act_n++;
      if (ls_w[0]) ls_n++;
      if (!hs_w[1]) h1_low++;
      if (!vs_w[1]) v1_low++;
      if (ft_w[1]) ft1_n++;
      if (vs_w[2]) v2_hi++;
      if (fs_w[2]) begin
        fs2_n++;
        if (fs2_n == 2) fs2_second = i;
      end
      if (i < 8) begin
        chk($sformatf("sx2_seq%0d", i), int'(sx_w[2]), exp_sx[i]);
        if (ft_w[2]) ft2_pat = ft2_pat | (1 << i);
      end
    end
    chk("hs0_cycles", hs_n, 96);
    chk("hs0_first_x", hs_first, 656);
    chk("ft0_per_line", ft_n, 80);
    chk("ft0_off_grid", ft_bad, 0);
    chk("act0_per_line", act_n, 640);
    chk("ls0_per_line", ls_n, 1);
    chk("hs1_low_cycles", h1_low, 100);
    chk("vs1_low_cycles", v1_low, 96);
    chk("ft1_every_active", ft1_n, 208);
    chk("vs2_high_cycles", v2_hi, 96);
    chk("fs2_count", fs2_n, 7);
    chk("fs2_period", fs2_second, 128);
    chk("ft2_pattern", ft2_pat, 8'h55);

    // Freeze the default DUT at CounterX=300 for 37 cycles.
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (int'(cx_w[0]) != 300 && g < 2000);
    chk("x300_reached", int'(g < 2000), 1);
    en[0] = 1'b0;
    repeat (37) @(posedge clk);
    @(negedge clk);
    chk("hold_cx", int'(cx_w[0]), 300);
    chk("hold_cy", int'(cy_w[0]), 1);
    chk("hold_ls", int'(ls_w[0]), 0);
    en[0] = 1'b1;
    @(negedge clk);
    chk("resume_cx", int'(cx_w[0]), 301);

    // Asynchronous reset in the middle of hsync.
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (int'(cx_w[0]) != 700 && g < 2000);
    chk("x700_reached", int'(g < 2000), 1);
    chk("pre_rst_hs", int'(hs_w[0]), 1);
    #1 rs[0] = 1'b1;
    #1;
    chk("rstmid_hs", int'(hs_w[0]), 0);
    chk("rstmid_vs", int'(vs_w[0]), 0);
    chk("rstmid_cx", int'(cx_w[0]), 0);
    chk("rstmid_cy", int'(cy_w[0]), 0);
    repeat (2) @(posedge clk);
    #2 rs[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_cx", int'(cx_w[0]), 0);
    chk("post_rst_cy", int'(cy_w[0]), 0);
    chk("post_rst_fs", int'(fs_w[0]), 1);
    chk("post_rst_ls", int'(ls_w[0]), 1);

    // Freeze the scaled small DUT right on a frameStart pixel.
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!fs_w[2] && g < 300);
    chk("fs2_reached", int'(g < 300), 1);
    en[2] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hold2_fs", int'(fs_w[2]), 0);
    chk("hold2_ls", int'(ls_w[2]), 0);
    chk("hold2_ft", int'(ft_w[2]), 0);
    chk("hold2_cx", int'(cx_w[2]), 0);
    chk("hold2_act", int'(act_w[2]), 1);
    en[2] = 1'b1;
    @(negedge clk);
    chk("resume2_cx", int'(cx_w[2]), 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, meaning horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, meaning vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameters HSYNC_POL / VSYNC_POL, default 1 / 1, meaning the asserted level of each sync.
REQ-006 SHALL have parameter SCALE_SHIFT, default 3, meaning pixel replication factor of 2^SCALE_SHIFT in X and Y (range 0..4).
REQ-007 SHALL have parameter CW, default 10, meaning the coordinate width; CW must hold H_TOTAL-1 and V_TOTAL-1.
REQ-008 PClk  input  1  pixel clock; all logic on its rising edge.
REQ-009 Reset  input  1  asynchronous, active-high reset.
REQ-010 Enable  input  1  when low, timing is frozen (counters and outputs hold).
REQ-011 hsync, vsync  output  1 each  sync outputs at configured polarity.
REQ-012 activeArea  output  1  high while the pixel is visible.
REQ-013 CounterX, CounterY  output  CW each  raw pixel and line position.
REQ-014 ScaledX, ScaledY  output  CW each  replicated coordinates.
REQ-015 fetchStrobe  output  1  one-cycle pulse requesting the next source pixel.
REQ-016 lineStart, frameStart  output  1 each  one-cycle pulses at x==0, and at x==0 && y==0.

Function
REQ-017 H_TOTAL and V_TOTAL SHALL be the sums of their four respective parameters; the defaults give 800 and 525.
REQ-018 The internal x counter SHALL count 0..H_TOTAL-1 and wrap to 0; y SHALL advance only on the x wrap, count 0..V_TOTAL-1 and wrap to 0.
REQ-019 Both counters SHALL advance only when Enable=1.
REQ-020 All outputs SHALL be registered from the internal (x,y) with exactly 1 cycle latency, so every output describes the same pixel on the same cycle.
REQ-021 activeArea SHALL be 1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-022 hsync SHALL equal HSYNC_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, and ~HSYNC_POL otherwise; the defaults give [656,752).
REQ-023 vsync SHALL equal VSYNC_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, and ~VSYNC_POL otherwise; the defaults give [490,492).
REQ-024 ScaledX SHALL be x>>SCALE_SHIFT when x<H_ACTIVE, else 0.
REQ-025 ScaledY SHALL be y>>SCALE_SHIFT when y<V_ACTIVE, else 0.
REQ-026 fetchStrobe SHALL be 1 iff activeArea conditions hold and x[SCALE_SHIFT-1:0]==0; with SCALE_SHIFT=0 it asserts on every active pixel.
REQ-027 When Enable=0, all outputs SHALL hold their previous values, and pulse outputs SHALL be forced to 0 (no repeated pulses).
REQ-028 When Enable rises again, timing SHALL resume from the held position with no skipped or duplicated pixel.
REQ-029 The wrap from x=H_TOTAL-1, y=V_TOTAL-1 SHALL produce x=0, y=0, and frameStart plus lineStart together one cycle later.

Reset
REQ-030 Reset SHALL asynchronously force x=0, y=0, CounterX=0, CounterY=0, ScaledX=0, ScaledY=0, activeArea=0, fetchStrobe=0, lineStart=0 and frameStart=0.
REQ-031 Reset SHALL force hsync=~HSYNC_POL and vsync=~VSYNC_POL.
REQ-032 Reset asserted mid-frame SHALL abandon the frame.
REQ-033 The first cycle after Reset release with Enable=1 SHALL register pixel (0,0): frameStart=1, activeArea=1, fetchStrobe=1.

Structure
REQ-034 Package video_timing_pkg SHALL hold the default timing constants (VGA 640x480@60) and a function computing the required CW from the totals.
REQ-035 Sub-module timing_axis_counter SHALL be instantiated twice, once for H and once for V.
REQ-036 timing_axis_counter SHALL take parameters ACTIVE, FP, SYNC, BP and POL, take an advance input, and produce count, wrap, active and sync outputs.
REQ-037 The top level SHALL chain H wrap into V advance and register the outputs.

Verification
REQ-038 Defaults, Enable=1, run 2 frames -> hsync high for exactly 96 cycles per line starting at CounterX=656; 525 lines per frame; frameStart once every 420000 cycles.
REQ-039 Defaults -> activeArea count per frame = 307200; fetchStrobe count per line = 80, at CounterX 0,8,...,632; ScaledY=59 on line 479.
REQ-040 HSYNC_POL=0, VSYNC_POL=0 -> hsync low only on x in [656,752); vsync low only on y in [490,492); both high during and after Reset.
REQ-041 Enable low for 37 cycles at CounterX=300 -> all outputs hold, no pulses; on re-enable the next CounterX is 301.
REQ-042 Reset pulse at (x=700, y=491) -> immediate hsync/vsync inactive and counters 0; next enabled cycle reports CounterX=0, CounterY=0, frameStart=1.
REQ-043 Small config H 8/2/2/4, V 4/1/1/2, SCALE_SHIFT=1 -> period 16x8=128 cycles; fetchStrobe at x=0,2,4,6; ScaledX sequence 0,0,1,1,2,2,3,3.
